mem_share_arbiter: RTL and testbench

Sequencing and arbitration front-end for the team's dual-port memory: synchronous write port, registered read port with rd_en and a synchronous clear.
- After reset, zero-fills the memory with an address sweep.
- Then shares the memory between two requesters (A, B) using round-robin req/gnt arbitration.
- Routes registered read data back with a per-requester valid.
- Sits between client logic and the memory instance. All memory-side signals are driven by registers in this block.

---
 rtl/mem_share_arbiter_pkg.sv | 19 +
 rtl/mem_share_arbiter_if.sv | 39 +++
 rtl/mem_share_arbiter_rr_arb2.sv | 52 +++++
 rtl/mem_share_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mem_share_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_share_arbiter_pkg.sv
// Shared types and constants for the memory-sharing arbiter.
// Holds the FSM state encoding, requester identifiers and read-return depth.
// Imported by the top, the round-robin arbiter and the client interface users.
package mem_share_arbiter_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_SERVE = 1'b1
  } state_t;

  // Requester identifiers double as bit positions in req/gnt vectors
  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  // Grant-to-rvalid distance: one edge to register the memory read command,
  // one edge for the memory to register its read data
  localparam int RD_LAT = 2;

endpackage

// File: rtl/mem_share_arbiter_if.sv
// Client-side bundle of the memory-sharing arbiter: two req/gnt command ports plus read return.
// Latency: none (wires only).
// Backpressure: a requester holds req and its command fields until it sees gnt.
interface mem_share_arbiter_if #(
  parameter int ADDR = 10,
  parameter int DATA = 32
);

  logic            a_req;
  logic            a_we;
  logic [ADDR-1:0] a_addr;
  logic [DATA-1:0] a_wdata;
  logic            a_gnt;
  logic            a_rvalid;

  logic            b_req;
  logic            b_we;
  logic [ADDR-1:0] b_addr;
  logic [DATA-1:0] b_wdata;
  logic            b_gnt;
  logic            b_rvalid;

  logic [DATA-1:0] rdata;

  // Arbiter side
  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    output a_gnt, a_rvalid, b_gnt, b_rvalid, rdata
  );

  // Client side
  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    input  a_gnt, a_rvalid, b_gnt, b_rvalid, rdata
  );

endinterface

// File: rtl/mem_share_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with a last-winner pointer.
// Latency: grant is combinational from req, enable and pointer; pointer updates on the granting edge.
// Backpressure: a losing requester keeps req high and is guaranteed the next contended grant.
module rr_arb2
  import mem_share_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic last_q;
  logic last_d;

  // Lone requester wins outright; on contention the one not granted last wins
  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      if (req_i == 2'b11) begin
        if (last_q == REQ_B) begin
          gnt_o[REQ_A] = 1'b1;
        end else begin
          gnt_o[REQ_B] = 1'b1;
        end
      end else begin
        gnt_o = req_i;
      end
    end
  end

  // Pointer only moves when somebody is actually granted
  always_comb begin
    last_d = last_q;
    if (gnt_o[REQ_A]) begin
      last_d = REQ_A;
    end else if (gnt_o[REQ_B]) begin
      last_d = REQ_B;
    end
  end

  // Reset to "B last" so A has first priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= REQ_B;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mem_share_arbiter.sv
// Sequencer/arbiter in front of a dual-port memory: post-reset fill sweep, then A/B round-robin sharing.
// Latency: command registered to the memory one edge after gnt; read data + rvalid two edges after gnt.
// Backpressure: no grants during the fill sweep; contending requesters alternate, at most one grant per cycle.
module mem_share_arbiter
  import mem_share_arbiter_pkg::*;
#(
  parameter int              ADDR     = 10,
  parameter int              DATA     = 32,
  parameter bit              INIT_EN  = 1'b1,
  parameter logic [DATA-1:0] INIT_VAL = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_share_arbiter_if.slave cli,
  output logic               init_done,
  output logic               mem_rst,
  output logic               mem_wr_en,
  output logic [ADDR-1:0]    mem_wr_addr,
  output logic [DATA-1:0]    mem_wr_data,
  output logic               mem_rd_en,
  output logic [ADDR-1:0]    mem_rd_addr,
  input  logic [DATA-1:0]    mem_rd_data
);

  localparam logic [ADDR-1:0] CNT_LAST = {ADDR{1'b1}};

  state_t          state_q, state_d;
  logic [ADDR-1:0] cnt_q, cnt_d;
  logic            init_done_q, init_done_d;
  logic            mem_rst_q, mem_rst_d;
  logic            wr_en_q, wr_en_d;
  logic [ADDR-1:0] wr_addr_q, wr_addr_d;
  logic [DATA-1:0] wr_data_q, wr_data_d;
  logic            rd_en_q, rd_en_d;
  logic [ADDR-1:0] rd_addr_q, rd_addr_d;

  // Read-return pipeline: valid and owner per stage
  logic [RD_LAT-1:0] pv_q, pv_d;
  logic [RD_LAT-1:0] po_q, po_d;

  logic            serve;
  logic [1:0]      req;
  logic [1:0]      gnt;
  logic            sel_b;
  logic            cmd_we;
  logic [ADDR-1:0] cmd_addr;
  logic [DATA-1:0] cmd_wdata;
  logic            rd_issue;

  assign serve      = (state_q == ST_SERVE);
  assign req[REQ_A] = cli.a_req;
  assign req[REQ_B] = cli.b_req;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (serve),
    .req_i (req),
    .gnt_o (gnt)
  );

  assign cli.a_gnt = gnt[REQ_A];
  assign cli.b_gnt = gnt[REQ_B];

  // Command fields are taken from whichever requester holds the grant
  assign sel_b     = gnt[REQ_B];
  assign cmd_we    = sel_b ? cli.b_we    : cli.a_we;
  assign cmd_addr  = sel_b ? cli.b_addr  : cli.a_addr;
  assign cmd_wdata = sel_b ? cli.b_wdata : cli.a_wdata;
  assign rd_issue  = (|gnt) & ~cmd_we;

  // Next-state for the FSM and every memory-side register
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    mem_rst_d   = mem_rst_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    rd_en_d     = 1'b0;
    rd_addr_d   = rd_addr_q;
    case (state_q)
      ST_INIT: begin
        if (INIT_EN) begin
          // One fill write per cycle; read register held in clear throughout
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q;
          wr_data_d = INIT_VAL;
          mem_rst_d = 1'b1;
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d     = ST_SERVE;
            init_done_d = 1'b1;
          end
        end else begin
          state_d     = ST_SERVE;
          init_done_d = 1'b1;
          mem_rst_d   = 1'b0;
        end
      end
      ST_SERVE: begin
        mem_rst_d = 1'b0;
        if (|gnt) begin
          if (cmd_we) begin
            wr_en_d   = 1'b1;
            wr_addr_d = cmd_addr;
            wr_data_d = cmd_wdata;
          end else begin
            rd_en_d   = 1'b1;
            rd_addr_d = cmd_addr;
          end
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // FSM state and registered memory-side outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      mem_rst_q   <= 1'b1;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      mem_rst_q   <= mem_rst_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
    end
  end

  // Shift read tags along with the memory's own read latency
  always_comb begin
    pv_d    = '0;
    po_d    = '0;
    pv_d[0] = rd_issue;
    po_d[0] = sel_b;
    for (int i = 1; i < RD_LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      po_d[i] = po_q[i-1];
    end
  end

  // Tags are dropped on reset so a read in flight never reports back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_q <= '0;
      po_q <= '0;
    end else begin
      pv_q <= pv_d;
      po_q <= po_d;
    end
  end

  assign cli.a_rvalid = pv_q[RD_LAT-1] & (po_q[RD_LAT-1] == REQ_A);
  assign cli.b_rvalid = pv_q[RD_LAT-1] & (po_q[RD_LAT-1] == REQ_B);
  assign cli.rdata    = mem_rd_data;

  assign init_done   = init_done_q;
  assign mem_rst     = mem_rst_q;
  assign mem_wr_en   = wr_en_q;
  assign mem_wr_addr = wr_addr_q;
  assign mem_wr_data = wr_data_q;
  assign mem_rd_en   = rd_en_q;
  assign mem_rd_addr = rd_addr_q;

endmodule

// File: tb/tb_mem_share_arbiter.sv
// Bench for mem_share_arbiter: fill sweep, arbitration, read return, mid-operation reset.
// Two instances: fill sweep enabled (main scoreboarded run) and disabled (timing only).
// A behavioural memory answers the memory port; a separate array model predicts read data.
module tb_mem_share_arbiter;

  localparam int ADDR = 4;
  localparam int DATA = 32;
  localparam int N    = 1 << ADDR;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic rst1_n = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit done1    = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- instance with fill sweep ----------------
  mem_share_arbiter_if #(.ADDR(ADDR), .DATA(DATA)) cli ();
  logic            init_done, mem_rst, mem_wr_en, mem_rd_en;
  logic [ADDR-1:0] mem_wr_addr, mem_rd_addr;
  logic [DATA-1:0] mem_wr_data, mem_rd_data;

  mem_share_arbiter #(.ADDR(ADDR), .DATA(DATA), .INIT_EN(1'b1), .INIT_VAL('0)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cli         (cli),
    .init_done   (init_done),
    .mem_rst     (mem_rst),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data)
  );

  logic [DATA-1:0] mem0 [N];
  always @(posedge clk) begin
    if (mem_wr_en) mem0[mem_wr_addr] <= mem_wr_data;
    if (mem_rst) mem_rd_data <= '0;
    else if (mem_rd_en) mem_rd_data <= mem0[mem_rd_addr];
  end

  // ---------------- instance without fill sweep ----------------
  mem_share_arbiter_if #(.ADDR(ADDR), .DATA(DATA)) cli1 ();
  logic            init_done1, mem_rst1, mem_wr_en1, mem_rd_en1;
  logic [ADDR-1:0] mem_wr_addr1, mem_rd_addr1;
  logic [DATA-1:0] mem_wr_data1, mem_rd_data1;

  mem_share_arbiter #(.ADDR(ADDR), .DATA(DATA), .INIT_EN(1'b0), .INIT_VAL('0)) u_dut1 (
    .clk         (clk),
    .rst_n       (rst1_n),
    .cli         (cli1),
    .init_done   (init_done1),
    .mem_rst     (mem_rst1),
    .mem_wr_en   (mem_wr_en1),
    .mem_wr_addr (mem_wr_addr1),
    .mem_wr_data (mem_wr_data1),
    .mem_rd_en   (mem_rd_en1),
    .mem_rd_addr (mem_rd_addr1),
    .mem_rd_data (mem_rd_data1)
  );

  logic [DATA-1:0] mem1 [N];
  always @(posedge clk) begin
    if (mem_wr_en1) mem1[mem_wr_addr1] <= mem_wr_data1;
    if (mem_rst1) mem_rd_data1 <= '0;
    else if (mem_rd_en1) mem_rd_data1 <= mem1[mem_rd_addr1];
  end

  // ---------------- reference model and scoreboard ----------------
  typedef struct {
    bit              own;   // 0 = A, 1 = B
    logic [DATA-1:0] data;
    int              due;   // cycle in which rvalid must be seen
  } exp_t;

  logic [DATA-1:0] m_mem [N];
  bit              m_last_b;
  bit              m_serve;
  exp_t            sbq[$];
  exp_t            mon_e;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Called at a negedge: predict grants from the round-robin rule, compare, then apply the command
  task automatic model_cycle(output bit ga, output bit gb);
    bit              we;
    int              addr;
    logic [DATA-1:0] wd;
    exp_t            e;
    ga = 1'b0;
    gb = 1'b0;
    if (m_serve) begin
      if (cli.a_req && cli.b_req) begin
        ga = m_last_b;
        gb = !m_last_b;
      end else begin
        ga = cli.a_req;
        gb = cli.b_req;
      end
    end
    chk("a_gnt", cli.a_gnt, ga);
    chk("b_gnt", cli.b_gnt, gb);
    if (ga || gb) begin
      we       = ga ? cli.a_we : cli.b_we;
      addr     = ga ? int'(cli.a_addr) : int'(cli.b_addr);
      wd       = ga ? cli.a_wdata : cli.b_wdata;
      m_last_b = gb;
      if (we) begin
        m_mem[addr] = wd;
      end else begin
        e.own  = gb;
        e.data = m_mem[addr];
        e.due  = cyc + 2;
        sbq.push_back(e);
      end
    end
  endtask

  task automatic tick(output bit ga, output bit gb);
    @(negedge clk);
    model_cycle(ga, gb);
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(bit req, bit we, int addr, logic [DATA-1:0] wd);
    cli.a_req   = req;
    cli.a_we    = we;
    cli.a_addr  = addr[ADDR-1:0];
    cli.a_wdata = wd;
  endtask

  task automatic set_b(bit req, bit we, int addr, logic [DATA-1:0] wd);
    cli.b_req   = req;
    cli.b_we    = we;
    cli.b_addr  = addr[ADDR-1:0];
    cli.b_wdata = wd;
  endtask

  // Expects rst_n low on entry; checks reset values, releases reset and follows the sweep
  task automatic init_seq();
    bit ga, gb;
    @(negedge clk);
    chk("rst_init_done", init_done, 0);
    chk("rst_mem_rst", mem_rst, 1);
    chk("rst_wr_en", mem_wr_en, 0);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_wr_addr", mem_wr_addr, 0);
    chk("rst_wr_data", mem_wr_data, 0);
    chk("rst_rvalid", {cli.a_rvalid, cli.b_rvalid}, 0);
    set_a(1, 0, 0, 0);
    set_b(0, 0, 0, 0);
    rst_n = 1'b1;
    for (int k = 1; k <= N; k++) begin
      @(negedge clk);
      chk("init_wr_en", mem_wr_en, 1);
      chk("init_wr_addr", mem_wr_addr, k - 1);
      chk("init_wr_data", mem_wr_data, 0);
      chk("init_done", init_done, (k == N));
      if (k < N) begin
        chk("init_a_gnt", cli.a_gnt, 0);
        chk("init_mem_rst", mem_rst, 1);
      end
    end
    for (int i = 0; i < N; i++) m_mem[i] = '0;
    m_last_b = 1'b1;
    m_serve  = 1'b1;
    // A's read held through the sweep is granted in the first serving cycle
    model_cycle(ga, gb);
    @(posedge clk);
    #1;
    set_a(0, 0, 0, 0);
  endtask

  // Monitor: every rvalid pops the oldest expected read and checks owner, data and cycle
  always @(negedge clk) begin
    if (cli.a_rvalid || cli.b_rvalid) begin
      if (cli.a_rvalid && cli.b_rvalid) begin
        checks++;
        failures++;
        $display("FAIL rvalid_both a=1 b=1 required at most one (cycle %0d)", cyc);
      end else if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rvalid_unexpected a=%0b b=%0b required none (cycle %0d)",
                 cli.a_rvalid, cli.b_rvalid, cyc);
      end else begin
        mon_e = sbq.pop_front();
        chk("rd_owner_b", cli.b_rvalid, mon_e.own);
        chk("rd_data", cli.rdata, mon_e.data);
        chk("rd_cycle", cyc, mon_e.due);
      end
    end else if (sbq.size() != 0 && sbq[0].due <= cyc) begin
      checks++;
      failures++;
      $display("FAIL rvalid_missing actual none required owner=%0d due=%0d (cycle %0d)",
               sbq[0].own, sbq[0].due, cyc);
      void'(sbq.pop_front());
    end
  end

  // ---------------- main stimulus ----------------
  initial begin
    bit       ga, gb;
    bit [5:0] seq;
    ga = 1'b0;
    gb = 1'b0;
    m_serve = 1'b0;
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    init_seq();
    repeat (3) tick(ga, gb);

    // Write then read-after-write of the same address from the other requester
    set_a(1, 1, 5, 32'hDEAD_BEEF);
    tick(ga, gb);
    set_a(0, 0, 0, 0);
    set_b(1, 0, 5, 0);
    tick(ga, gb);
    set_b(0, 0, 0, 0);
    repeat (4) tick(ga, gb);

    // Both requesters held: grants must alternate starting with A
    set_a(1, 0, 1, 0);
    set_b(1, 0, 2, 0);
    seq = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      seq = {seq[4:0], cli.a_gnt};
      model_cycle(ga, gb);
      @(posedge clk);
      #1;
    end
    chk("rr_sequence_a", seq, 6'b101010);
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    repeat (3) tick(ga, gb);

    // Distinct data at 1..3, then back-to-back reads from B
    for (int i = 1; i <= 3; i++) begin
      set_a(1, 1, i, 32'h1111_0000 + i);
      tick(ga, gb);
    end
    set_a(0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      set_b(1, 0, i, 0);
      tick(ga, gb);
    end
    set_b(0, 0, 0, 0);
    repeat (4) tick(ga, gb);

    // Randomised traffic: requests held until granted
    ga = 1'b0;
    gb = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!cli.a_req || ga) begin
        if ($urandom_range(0, 3) != 0) set_a(1, $urandom_range(0, 1), $urandom_range(0, 7), $urandom);
        else set_a(0, 0, 0, 0);
      end
      if (!cli.b_req || gb) begin
        if ($urandom_range(0, 3) != 0) set_b(1, $urandom_range(0, 1), $urandom_range(0, 7), $urandom);
        else set_b(0, 0, 0, 0);
      end
      tick(ga, gb);
    end
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    repeat (5) tick(ga, gb);

    // Read granted, then asynchronous reset in the following cycle
    set_a(1, 0, 3, 0);
    tick(ga, gb);
    set_a(0, 0, 0, 0);
    rst_n   = 1'b0;
    m_serve = 1'b0;
    sbq.delete();
    #1;
    chk("arst_init_done", init_done, 0);
    chk("arst_rd_en", mem_rd_en, 0);
    chk("arst_mem_rst", mem_rst, 1);
    chk("arst_rvalid", {cli.a_rvalid, cli.b_rvalid}, 0);
    @(posedge clk);
    #1;
    init_seq();
    repeat (6) tick(ga, gb);

    for (int i = 0; i < 1000 && !done1; i++) @(posedge clk);
    chk("nofill_done", done1, 1);
    chk("sb_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- instance without fill sweep ----------------
  initial begin
    int t;
    int first;
    int nvld;
    cli1.a_req = 1'b0; cli1.a_we = 1'b0; cli1.a_addr = '0; cli1.a_wdata = '0;
    cli1.b_req = 1'b0; cli1.b_we = 1'b0; cli1.b_addr = '0; cli1.b_wdata = '0;
    rst1_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("nofill_rst_done", init_done1, 0);
    chk("nofill_rst_mem_rst", mem_rst1, 1);
    rst1_n = 1'b1;
    @(negedge clk);
    chk("nofill_init_done", init_done1, 1);
    chk("nofill_mem_rst", mem_rst1, 0);
    chk("nofill_wr_en", mem_wr_en1, 0);
    cli1.a_req  = 1'b1;
    cli1.a_addr = 4'd9;
    #1;
    chk("nofill_a_gnt", cli1.a_gnt, 1);
    t = cyc;
    @(posedge clk);
    #1;
    cli1.a_req = 1'b0;
    first = -1;
    nvld  = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (cli1.a_rvalid) begin
        nvld++;
        if (first < 0) first = cyc;
      end
      chk("nofill_b_rvalid", cli1.b_rvalid, 0);
    end
    chk("nofill_rvalid_cycle", first, t + 2);
    chk("nofill_rvalid_count", nvld, 1);
    done1 = 1'b1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench did not finish");
  end

endmodule
